// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions for the multicycle CPU datapath.
// Holds the ALU command codes used by the control FSM (including SLTU for
// the iterative comparator) and the state encoding of slt_iterative.
package alu_defs;

  typedef enum logic [3:0] {
    ADD     = 4'd0,
    SUB     = 4'd1,
    XOR_SEL = 4'd2,
    SLT     = 4'd3,
    AND_SEL = 4'd4,
    NAND    = 4'd5,
    NOR     = 4'd6,
    OR_SEL  = 4'd7,
    SLTU    = 4'd8
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slt_state_e;

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract slice: sum = x + ~y + cin.
// Ports:
//   x, y  : CHUNK-bit operand slices
//   cin   : carry in (1 on the first slice, i.e. the +1 of two's complement)
//   sum   : CHUNK-bit slice result
//   cout  : carry out of the slice
//   cmsb  : carry into the slice MSB (signed overflow on the top slice)
module sub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] y_n;
  logic [CHUNK:0]   full;

  always_comb begin
    y_n  = ~y;
    full = {1'b0, x} + {1'b0, y_n} + (CHUNK+1)'(cin);
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit; works for CHUNK=1.
    cmsb = sum[CHUNK-1] ^ x[CHUNK-1] ^ y_n[CHUNK-1];
  end

endmodule

// File: rtl/slt_iterative.sv
// Multi-cycle set-less-than unit. Computes a - b one CHUNK-bit slice per
// cycle (LSB first) with a registered carry and reports signed (SLT) or
// unsigned (SLTU) less-than plus an equality flag.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (ready only in IDLE)
//   a, b, is_unsigned     : operands and compare mode, latched on accept
//   out_valid / out_ready : result handshake (result held until consumed)
//   result                : {0..., lt}
//   eq                    : a == b
module slt_iterative
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  slt_state_e        state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              uns_q;
  logic              carry_q;
  logic              zero_q;
  logic [IDX_W-1:0]  idx_q;

  logic [CHUNK-1:0]  x_s;
  logic [CHUNK-1:0]  y_s;
  logic [CHUNK-1:0]  sum_s;
  logic              cout_s;
  logic              cmsb_s;
  logic              zero_d;
  logic              last_d;
  logic              lt_d;

  always_comb begin
    x_s    = a_q[idx_q*CHUNK +: CHUNK];
    y_s    = b_q[idx_q*CHUNK +: CHUNK];
    zero_d = zero_q & (sum_s == '0);
    last_d = (idx_q == IDX_W'(N - 1));
    // Signed: d_msb ^ ovf, ovf = carry-into-MSB ^ carry-out. Unsigned: borrow.
    lt_d   = uns_q ? ~cout_s : (sum_s[CHUNK-1] ^ cmsb_s ^ cout_s);
  end

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_sub (
    .x    (x_s),
    .y    (y_s),
    .cin  (carry_q),
    .sum  (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      eq        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      uns_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            uns_q    <= is_unsigned;
            carry_q  <= 1'b1;
            zero_q   <= 1'b1;
            idx_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          carry_q <= cout_s;
          zero_q  <= zero_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_d) begin
            result    <= WIDTH'(lt_d);
            eq        <= zero_d;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
